// File: rtl/qpu_exu_timing_ctrl_pkg.sv
// Shared constants and types for the QPU execution-unit timing controller.
// Entry layout is {has_op, interval, op} with op in the low bits.
package qpu_exu_timing_ctrl_pkg;

    localparam int QPU_TIME_W     = 20;
    localparam int QPU_INSTR_SIZE = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tctrl_state_e;

    function automatic int entry_w(input int time_w, input int op_w);
        return 1 + time_w + op_w;
    endfunction

endpackage

// File: rtl/qpu_timing_fifo.sv
// In-order timing-entry buffer; flush empties it on the next edge.
module qpu_timing_fifo
    import qpu_exu_timing_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = entry_w(QPU_TIME_W, QPU_INSTR_SIZE),
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rd_ptr];

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qpu_exu_timing_ctrl.sv
// Timing-point scheduler: releases each buffered entry a fixed number of
// cycles after the previous release and flags entries that arrive late.
module qpu_exu_timing_ctrl
    import qpu_exu_timing_ctrl_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TIME_W = QPU_TIME_W,
    parameter int OP_W   = QPU_INSTR_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [TIME_W-1:0] i_interval,
    input  logic              i_has_op,
    input  logic [OP_W-1:0]   i_op,
    input  logic              i_flush,
    output logic              o_trig_valid,
    output logic              o_trig_has_op,
    output logic [OP_W-1:0]   o_trig_op,
    output logic              o_trig_same_tp,
    output logic              o_busy,
    output logic              o_underrun,
    output logic [TIME_W-1:0] o_timer
);

    localparam int ENTRY_W = entry_w(TIME_W, OP_W);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int OP_LSB  = 0;
    localparam int IV_LSB  = OP_W;
    localparam int HAS_BIT = OP_W + TIME_W;

    function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] t);
        return (&t) ? t : t + TIME_W'(1);
    endfunction

    tctrl_state_e      state;
    logic [TIME_W-1:0] timer_p1;
    logic              trig_valid_p1;
    logic              trig_has_op_p1;
    logic [OP_W-1:0]   trig_op_p1;
    logic              trig_same_tp_p1;
    logic              underrun_p1;

    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;
    logic               head_has;
    logic [TIME_W-1:0]  head_iv;
    logic [TIME_W-1:0]  head_eff;
    logic [OP_W-1:0]    head_op;
    logic [TIME_W:0]    timer_nx;
    logic               due;
    logic               late;

    assign i_ready  = ~fifo_full;
    assign push     = i_valid & i_ready & ~i_flush;
    assign head_has = head[HAS_BIT];
    assign head_iv  = head[IV_LSB +: TIME_W];
    assign head_op  = head[OP_LSB +: OP_W];
    assign head_eff = (head_iv == '0) ? TIME_W'(1) : head_iv;

    // Widened compare so a saturated timer still orders correctly.
    assign timer_nx = {1'b0, timer_p1} + (TIME_W + 1)'(1);
    assign due      = (timer_nx >= {1'b0, head_eff});
    assign late     = (timer_nx >  {1'b0, head_eff});
    assign pop      = (state == ST_RUN) & ~fifo_empty & due & ~i_flush;

    qpu_timing_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (i_flush),
        .push  (push),
        .wdata ({i_has_op, i_interval, i_op}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            timer_p1        <= '0;
            underrun_p1     <= 1'b0;
            trig_valid_p1   <= 1'b0;
            trig_has_op_p1  <= 1'b0;
            trig_op_p1      <= '0;
            trig_same_tp_p1 <= 1'b0;
        end else if (i_flush) begin
            state           <= ST_IDLE;
            timer_p1        <= '0;
            underrun_p1     <= 1'b0;
            trig_valid_p1   <= 1'b0;
            trig_has_op_p1  <= 1'b0;
            trig_op_p1      <= '0;
            trig_same_tp_p1 <= 1'b0;
        end else begin
            trig_valid_p1   <= 1'b0;
            trig_has_op_p1  <= 1'b0;
            trig_op_p1      <= '0;
            trig_same_tp_p1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (push) begin
                        state    <= ST_RUN;
                        timer_p1 <= '0;
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        timer_p1        <= '0;
                        trig_valid_p1   <= 1'b1;
                        trig_has_op_p1  <= head_has;
                        trig_op_p1      <= head_has ? head_op : '0;
                        trig_same_tp_p1 <= (head_iv == '0);
                        if (late) begin
                            underrun_p1 <= 1'b1;
                        end
                    end else begin
                        timer_p1 <= sat_inc(timer_p1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_trig_valid   = trig_valid_p1;
    assign o_trig_has_op  = trig_has_op_p1;
    assign o_trig_op      = trig_op_p1;
    assign o_trig_same_tp = trig_same_tp_p1;
    assign o_underrun     = underrun_p1;
    assign o_timer        = timer_p1;
    assign o_busy         = (fifo_count != '0);

endmodule
